// File: rtl/loop_gain_scheduler.sv
// Gain and reset sequencer for the ADPLL loop filter: walks IDLE -> ACQ -> TRACK -> LOCK
// from the magnitude of the phase error, qualifying each step with consecutive-sample counts.
module loop_gain_scheduler #(
    parameter int                  ERROR_WIDTH   = 8,
    parameter int                  KP_WIDTH      = 3,
    parameter int                  KI_WIDTH      = 4,
    parameter logic [KP_WIDTH-1:0] KP_ACQ        = 3'b100,
    parameter logic [KI_WIDTH-1:0] KI_ACQ        = 4'b0100,
    parameter logic [KP_WIDTH-1:0] KP_TRK        = 3'b001,
    parameter logic [KI_WIDTH-1:0] KI_TRK        = 4'b0001,
    parameter int                  ACQ_THRESH    = 16,
    parameter int                  LOCK_THRESH   = 4,
    parameter int                  UNLOCK_THRESH = 32,
    parameter int                  ACQ_COUNT     = 16,
    parameter int                  LOCK_COUNT    = 64,
    parameter int                  UNLOCK_COUNT  = 8
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic        [KP_WIDTH-1:0]    kp_o,
    output logic        [KI_WIDTH-1:0]    ki_o,
    output logic                          filter_reset_o,
    output logic                          locked_o,
    output logic        [1:0]             state_o
);

    localparam int MAX_AL    = (ACQ_COUNT > LOCK_COUNT) ? ACQ_COUNT : LOCK_COUNT;
    localparam int MAX_COUNT = (MAX_AL > UNLOCK_COUNT) ? MAX_AL : UNLOCK_COUNT;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(ACQ_COUNT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);

    localparam logic [ERROR_WIDTH-1:0] ERR_ONE = ERROR_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACQ   = 2'b01,
        S_TRACK = 2'b10,
        S_LOCK  = 2'b11
    } state_t;

    // Magnitude of a two's-complement error; the most-negative code has no
    // positive twin, so it clamps to the largest positive value.
    function automatic logic [ERROR_WIDTH-1:0] abs_sat(input logic [ERROR_WIDTH-1:0] e);
        if (!e[ERROR_WIDTH-1])
            return e;
        else if (e[ERROR_WIDTH-2:0] == '0)
            return ERR_MAX;
        else
            return ~e + ERR_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [KP_WIDTH-1:0]   r_kp;
    logic [KI_WIDTH-1:0]   r_ki;
    logic                  r_filter_reset;
    logic                  r_locked;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [31:0]           w_abs;
    logic                  w_acq_ok;
    logic                  w_lock_ok;
    logic                  w_unlock;

    assign w_abs     = {{(32-ERROR_WIDTH){1'b0}}, abs_sat(error_i)};
    assign w_acq_ok  = (w_abs <= 32'(ACQ_THRESH));
    assign w_lock_ok = (w_abs <= 32'(LOCK_THRESH));
    assign w_unlock  = (w_abs >  32'(UNLOCK_THRESH));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!enable_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQ;
                    w_cnt_nxt   = CNT_ZERO;
                end
                S_ACQ: begin
                    if (!w_acq_ok) begin
                        w_cnt_nxt = CNT_ZERO;
                    end else if (r_cnt >= ACQ_LAST) begin
                        w_state_nxt = S_TRACK;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = cnt_inc(r_cnt);
                    end
                end
                S_TRACK: begin
                    // A single large excursion abandons tracking before any counting.
                    if (w_unlock) begin
                        w_state_nxt = S_ACQ;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (!w_lock_ok) begin
                        w_cnt_nxt = CNT_ZERO;
                    end else if (r_cnt >= LOCK_LAST) begin
                        w_state_nxt = S_LOCK;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = cnt_inc(r_cnt);
                    end
                end
                default: begin
                    if (!w_unlock) begin
                        w_cnt_nxt = CNT_ZERO;
                    end else if (r_cnt >= UNLOCK_LAST) begin
                        w_state_nxt = S_ACQ;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = cnt_inc(r_cnt);
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            r_state        <= S_IDLE;
            r_cnt          <= CNT_ZERO;
            r_kp           <= KP_ACQ;
            r_ki           <= KI_ACQ;
            r_filter_reset <= 1'b1;
            r_locked       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_kp           <= w_state_nxt[1] ? KP_TRK : KP_ACQ;
            r_ki           <= w_state_nxt[1] ? KI_TRK : KI_ACQ;
            r_filter_reset <= (w_state_nxt == S_IDLE);
            r_locked       <= (w_state_nxt == S_LOCK);
        end
    end

    assign kp_o           = r_kp;
    assign ki_o           = r_ki;
    assign filter_reset_o = r_filter_reset;
    assign locked_o       = r_locked;
    assign state_o        = r_state;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Directed bench for loop_gain_scheduler: a vector table for reset/entry behaviour
// followed by hand-written sequences for the consecutive-sample qualification paths.
module tb_loop_gain_scheduler;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ACQ   = 2'b01;
    localparam logic [1:0] ST_TRACK = 2'b10;
    localparam logic [1:0] ST_LOCK  = 2'b11;

    logic              gen_clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              enable_i  = 1'b0;
    logic signed [7:0] error_i   = '0;
    logic [2:0]        kp_o;
    logic [3:0]        ki_o;
    logic              filter_reset_o;
    logic              locked_o;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;

    loop_gain_scheduler dut (
        .gen_clk_i      (gen_clk_i),
        .reset_n_i      (reset_n_i),
        .enable_i       (enable_i),
        .error_i        (error_i),
        .kp_o           (kp_o),
        .ki_o           (ki_o),
        .filter_reset_o (filter_reset_o),
        .locked_o       (locked_o),
        .state_o        (state_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    typedef struct {
        logic              rst_n;
        logic              en;
        logic signed [7:0] err;
        logic [1:0]        exp_st;
    } vec_t;

    vec_t vecs [8];

    // Expected output bundle {state, kp, ki, filter_reset, locked} for a given state.
    function automatic logic [10:0] expect_of(input logic [1:0] st);
        logic [2:0] kp;
        logic [3:0] ki;
        kp = (st == ST_TRACK || st == ST_LOCK) ? 3'b001 : 3'b100;
        ki = (st == ST_TRACK || st == ST_LOCK) ? 4'b0001 : 4'b0100;
        return {st, kp, ki, (st == ST_IDLE), (st == ST_LOCK)};
    endfunction

    task automatic apply(input logic rst_n, input logic en, input logic signed [7:0] err,
                         input logic [1:0] exp_st, input string name);
        logic [10:0] got;
        logic [10:0] exp;
        reset_n_i = rst_n;
        enable_i  = en;
        error_i   = err;
        @(posedge gen_clk_i);
        #1;
        got = {state_o, kp_o, ki_o, filter_reset_o, locked_o};
        exp = expect_of(exp_st);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%b kp=%b ki=%b frst=%b lock=%b, expected st=%b kp=%b ki=%b frst=%b lock=%b",
                     name, got[10:9], got[8:6], got[5:2], got[1], got[0],
                     exp[10:9], exp[8:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // n edges with constant error: the first n-1 expect st_hold, the last expects st_last.
    task automatic run(input int n, input logic signed [7:0] err, input logic [1:0] st_hold,
                       input logic [1:0] st_last, input string name);
        for (int k = 1; k < n; k++)
            apply(1'b1, 1'b1, err, st_hold, name);
        apply(1'b1, 1'b1, err, st_last, name);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0,   8'sd0, ST_IDLE};
        vecs[1] = '{1'b0, 1'b0,   8'sd0, ST_IDLE};
        vecs[2] = '{1'b1, 1'b0,  8'sd10, ST_IDLE};
        vecs[3] = '{1'b1, 1'b1,  8'sd10, ST_ACQ};
        vecs[4] = '{1'b1, 1'b1, -8'sd17, ST_ACQ};
        vecs[5] = '{1'b1, 1'b1, -8'sd16, ST_ACQ};
        vecs[6] = '{1'b1, 1'b0,  8'sd10, ST_IDLE};
        vecs[7] = '{1'b1, 1'b1,  8'sd10, ST_ACQ};

        for (int i = 0; i < 8; i++)
            apply(vecs[i].rst_n, vecs[i].en, vecs[i].err, vecs[i].exp_st, $sformatf("vec%0d", i));

        // ACQ entered on vecs[7]; the 16th qualifying sample moves to TRACK.
        run(16, 8'sd10, ST_ACQ, ST_TRACK, "acq_to_track");

        run(63, 8'sd3, ST_TRACK, ST_TRACK, "track_count_a");
        apply(1'b1, 1'b1, 8'sd5, ST_TRACK, "track_break");
        run(64, 8'sd3, ST_TRACK, ST_LOCK, "track_to_lock");

        run(7, -8'sd40, ST_LOCK, ST_LOCK, "lock_hold_7");
        apply(1'b1, 1'b1, 8'sd0, ST_LOCK, "lock_break");
        run(8, -8'sd40, ST_LOCK, ST_ACQ, "lock_to_acq");

        // Threshold edges: 16 qualifies for ACQ, 32 is not an unlock sample.
        run(16, 8'sd16, ST_ACQ, ST_TRACK, "acq_thresh_edge");
        apply(1'b1, 1'b1, 8'sd32, ST_TRACK, "unlock_thresh_edge");
        apply(1'b1, 1'b1, -8'sd128, ST_ACQ, "neg_sat_reacq");

        run(16, 8'sd0, ST_ACQ, ST_TRACK, "reacq_a");
        run(64, -8'sd4, ST_TRACK, ST_LOCK, "lock_thresh_edge");
        run(5, -8'sd40, ST_LOCK, ST_LOCK, "lock_partial");
        apply(1'b1, 1'b0, -8'sd40, ST_IDLE, "enable_drop_lock");
        apply(1'b1, 1'b1, 8'sd0, ST_ACQ, "enable_back");
        run(16, 8'sd0, ST_ACQ, ST_TRACK, "reacq_b");
        run(64, 8'sd0, ST_TRACK, ST_LOCK, "relock_b");
        run(7, -8'sd40, ST_LOCK, ST_LOCK, "unlock_cnt_cleared");
        apply(1'b0, 1'b1, -8'sd40, ST_IDLE, "reset_in_lock");
        apply(1'b1, 1'b1, 8'sd0, ST_ACQ, "reset_release");
        run(15, 8'sd0, ST_ACQ, ST_ACQ, "acq_almost");
        apply(1'b1, 1'b0, 8'sd0, ST_IDLE, "enable_vs_acq_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
